// File: rtl/sigma_mailbox_pkg.sv
// Shared constants for the sigma mailbox: register indices decoded from
// bus address bits [4:2] and the bit layout of the STATUS word.
package sigma_mailbox_pkg;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_IRQ_EN = 3'd3;
    localparam logic [2:0] REG_THRESH = 3'd4;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_UNF       = 3;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_MSB = 16;

    localparam int THRESH_W = 9;

endpackage

// File: rtl/sigma_mailbox_if.sv
// Crossbar slave-port bundle for the sigma mailbox; master drives requests,
// slave returns ack and the delayed read response.
interface sigma_mailbox_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );

endinterface

// File: rtl/sigma_mailbox_fifo.sv
// Word FIFO behind the mailbox. Storage is deliberately left unreset; only
// pointers and the occupancy count return to zero.
module sigma_mailbox_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == CNT_DEPTH);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign count     = count_r;
    assign rdata     = mem_r[rptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Data array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/sigma_mailbox.sv
// Sigma mailbox top: register decode, sticky OVF/UNF flags, THRESH/IRQ_EN
// and the interrupt. Interrupt logic is built only with SIGMA_MAILBOX_IRQ_EN.
module sigma_mailbox
    import sigma_mailbox_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int THRESH_RST = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sigma_mailbox_if.slave    bus,
    output logic              irq_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [2:0]          idx_s;
    logic                rd_s;
    logic                wr_s;
    logic                push_s;
    logic                pop_s;
    logic                ovf_set_s;
    logic                unf_set_s;
    logic                st_clr_s;
    logic                thresh_wr_s;
    logic [31:0]         fifo_rdata_s;
    logic [CW-1:0]       count_s;
    logic [THRESH_W-1:0] count9_s;
    logic                empty_s;
    logic                full_s;
    logic [1:0]          irq_en_s;
    logic [31:0]         status_s;
    logic [31:0]         rdata_s;
    logic                ovf_r;
    logic                unf_r;
    logic [THRESH_W-1:0] thresh_r;
    logic                resp_r;
    logic [31:0]         rdata_r;
    logic                unused_s;

    assign idx_s     = bus.addr[4:2];
    assign rd_s      = bus.req & ~bus.we;
    assign wr_s      = bus.req & bus.we;
    assign push_s    = wr_s & (idx_s == REG_TXDATA) & ~full_s;
    assign ovf_set_s = wr_s & (idx_s == REG_TXDATA) & full_s;
    assign pop_s     = rd_s & (idx_s == REG_RXDATA) & ~empty_s;
    assign unf_set_s = rd_s & (idx_s == REG_RXDATA) & empty_s;
    assign st_clr_s  = wr_s & (idx_s == REG_STATUS) & bus.be[0];
    assign thresh_wr_s = wr_s & (idx_s == REG_THRESH);
    assign count9_s  = THRESH_W'(count_s);
    assign unused_s  = ^{bus.addr[31:5], bus.addr[1:0], bus.be[3:2]};

    assign bus.ack   = bus.req;
    assign bus.resp  = resp_r;
    assign bus.rdata = rdata_r;

    sigma_mailbox_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (bus.wdata),
        .rdata (fifo_rdata_s),
        .count (count_s),
        .empty (empty_s),
        .full  (full_s)
    );

    // STATUS word assembled from current (pre-update) state.
    always_comb begin
        status_s                            = 32'd0;
        status_s[ST_EMPTY]                  = empty_s;
        status_s[ST_FULL]                   = full_s;
        status_s[ST_OVF]                    = ovf_r;
        status_s[ST_UNF]                    = unf_r;
        status_s[ST_COUNT_MSB:ST_COUNT_LSB] = count9_s;
    end

    // Read data mux; an empty RXDATA read returns zero.
    always_comb begin
        rdata_s = 32'd0;
        case (idx_s)
            REG_TXDATA: rdata_s = 32'd0;
            REG_RXDATA: begin
                if (empty_s) begin
                    rdata_s = 32'd0;
                end else begin
                    rdata_s = fifo_rdata_s;
                end
            end
            REG_STATUS: rdata_s = status_s;
            REG_IRQ_EN: rdata_s = {30'd0, irq_en_s};
            REG_THRESH: rdata_s = {23'd0, thresh_r};
            default:    rdata_s = 32'd0;
        endcase
    end

    // Sticky flags: a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (st_clr_s && bus.wdata[ST_OVF]) begin
                ovf_r <= 1'b0;
            end
            if (unf_set_s) begin
                unf_r <= 1'b1;
            end else if (st_clr_s && bus.wdata[ST_UNF]) begin
                unf_r <= 1'b0;
            end
        end
    end

    // THRESH register; bit 8 sits in the second byte lane.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            thresh_r <= THRESH_RST[THRESH_W-1:0];
        end else if (thresh_wr_s) begin
            if (bus.be[0]) begin
                thresh_r[7:0] <= bus.wdata[7:0];
            end
            if (bus.be[1]) begin
                thresh_r[8] <= bus.wdata[8];
            end
        end
    end

    // Read response: one cycle after acceptance, data zero when idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_r  <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            resp_r  <= rd_s;
            rdata_r <= rd_s ? rdata_s : 32'd0;
        end
    end

`ifdef SIGMA_MAILBOX_IRQ_EN
    logic [1:0] irq_en_r;
    logic       irq_r;

    assign irq_en_s = irq_en_r;
    assign irq_o    = irq_r;

    // Interrupt enable register and registered level interrupt.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en_r <= 2'b00;
            irq_r    <= 1'b0;
        end else begin
            if (wr_s && (idx_s == REG_IRQ_EN) && bus.be[0]) begin
                irq_en_r <= bus.wdata[1:0];
            end
            irq_r <= (irq_en_r[0] & ~empty_s) |
                     (irq_en_r[1] & (count9_s >= thresh_r));
        end
    end
`else
    assign irq_en_s = 2'b00;
    assign irq_o    = 1'b0;
`endif

endmodule

// File: tb/tb_sigma_mailbox.sv
// Scoreboard bench for sigma_mailbox: reads push their expected data, the
// negedge monitor pops and compares each response.
module tb_sigma_mailbox;
    import sigma_mailbox_pkg::*;

    logic clk;
    logic rst;
    logic irq;
    int   n_cmp;
    int   n_err;
    logic [31:0] sb[$];

    sigma_mailbox_if mb_if();

    sigma_mailbox #(.DEPTH(8), .THRESH_RST(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (mb_if.slave),
        .irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic bus_op(input logic we, input logic [2:0] idx, input logic [3:0] be,
                          input logic [31:0] wdata);
        @(negedge clk);
        mb_if.req   = 1'b1;
        mb_if.we    = we;
        mb_if.addr  = {27'd0, idx, 2'b00};
        mb_if.be    = be;
        mb_if.wdata = wdata;
        #1 chk("ack", {31'd0, mb_if.ack}, 32'd1);
        @(posedge clk);
        #1;
        mb_if.req = 1'b0;
        mb_if.we  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] be);
        bus_op(1'b1, idx, be, d);
    endtask

    task automatic rd(input logic [2:0] idx, input logic [31:0] exp);
        sb.push_back(exp);
        bus_op(1'b0, idx, 4'hF, 32'd0);
    endtask

    // Response monitor: every resp must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (mb_if.resp) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", {31'd0, mb_if.resp}, 32'd0);
                end else begin
                    chk("rdata", mb_if.rdata, sb.pop_front());
                end
            end else begin
                chk("rdata_idle", mb_if.rdata, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        mb_if.req = 1'b0; mb_if.we = 1'b0; mb_if.addr = 32'd0;
        mb_if.be = 4'h0; mb_if.wdata = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_resp", {31'd0, mb_if.resp}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        rd(REG_STATUS, 32'h1);

        wr(REG_TXDATA, 32'hA5A5_0001, 4'h0);
        wr(REG_TXDATA, 32'hA5A5_0002, 4'hF);
        rd(REG_STATUS, 32'h200);
        rd(REG_RXDATA, 32'hA5A5_0001);
        rd(REG_RXDATA, 32'hA5A5_0002);
        rd(REG_STATUS, 32'h1);

        for (int i = 0; i < 9; i++) wr(REG_TXDATA, 32'h1000 + i, 4'hF);
        rd(REG_STATUS, 32'h806);
        for (int i = 0; i < 8; i++) rd(REG_RXDATA, 32'h1000 + i);
        rd(REG_STATUS, 32'h5);
        rd(REG_RXDATA, 32'h0);
        rd(REG_STATUS, 32'hD);
        wr(REG_STATUS, 32'h4, 4'h1);
        rd(REG_STATUS, 32'h9);
        wr(REG_STATUS, 32'h8, 4'h0);
        rd(REG_STATUS, 32'h9);
        wr(REG_STATUS, 32'h8, 4'h1);
        rd(REG_STATUS, 32'h1);

        wr(REG_RXDATA, 32'hDEAD_BEEF, 4'hF);
        rd(REG_STATUS, 32'h1);
        rd(REG_TXDATA, 32'h0);
        wr(3'd6, 32'h1234_5678, 4'hF);
        rd(3'd6, 32'h0);
        rd(3'd5, 32'h0);

        rd(REG_THRESH, 32'h1);
        wr(REG_THRESH, 32'h1FF, 4'h1);
        rd(REG_THRESH, 32'hFF);
        wr(REG_THRESH, 32'h100, 4'h2);
        rd(REG_THRESH, 32'h1FF);
        wr(REG_THRESH, 32'h3, 4'hF);
        rd(REG_THRESH, 32'h3);

`ifdef SIGMA_MAILBOX_IRQ_EN
        wr(REG_IRQ_EN, 32'h2, 4'h1);
        rd(REG_IRQ_EN, 32'h2);
        wr(REG_TXDATA, 32'hC0DE_0001, 4'hF);
        wr(REG_TXDATA, 32'hC0DE_0002, 4'hF);
        repeat (2) @(negedge clk);
        chk("irq_below", {31'd0, irq}, 32'd0);
        wr(REG_TXDATA, 32'hC0DE_0003, 4'hF);
        repeat (2) @(negedge clk);
        chk("irq_at_thresh", {31'd0, irq}, 32'd1);
        rd(REG_RXDATA, 32'hC0DE_0001);
        repeat (2) @(negedge clk);
        chk("irq_after_pop", {31'd0, irq}, 32'd0);
        rd(REG_RXDATA, 32'hC0DE_0002);
        rd(REG_RXDATA, 32'hC0DE_0003);
        wr(REG_IRQ_EN, 32'h0, 4'h1);
`else
        wr(REG_IRQ_EN, 32'h3, 4'hF);
        rd(REG_IRQ_EN, 32'h0);
        wr(REG_TXDATA, 32'hC0DE_0001, 4'hF);
        repeat (2) @(negedge clk);
        chk("irq_tied", {31'd0, irq}, 32'd0);
        rd(REG_RXDATA, 32'hC0DE_0001);
`endif

        for (int i = 0; i < 4; i++) wr(REG_TXDATA, 32'hBEEF_0000 + i, 4'hF);
        rd(REG_STATUS, 32'h400);
        rd(REG_RXDATA, 32'hBEEF_0000);
        chk("resp_pre_rst", {31'd0, mb_if.resp}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_resp", {31'd0, mb_if.resp}, 32'd0);
        chk("async_rst_rdata", mb_if.rdata, 32'd0);
        chk("async_rst_irq", {31'd0, irq}, 32'd0);
        sb.delete();
        @(negedge clk);
        mb_if.req  = 1'b1;
        mb_if.we   = 1'b0;
        mb_if.addr = {27'd0, REG_STATUS, 2'b00};
        @(negedge clk);
        mb_if.req = 1'b0;
        rst = 1'b0;
        rd(REG_STATUS, 32'h1);
        rd(REG_THRESH, 32'h1);

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
